// File: rtl/csr_arbiter_if.sv
// Two-master CSR bus bundle: master request/response pairs plus the shared
// CSR slave bus, seen from the arbiter (slave) and from its environment.
interface csr_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic                  m0_req;
  logic [ADDR_WIDTH-1:0] m0_a;
  logic [DATA_WIDTH-1:0] m0_di;
  logic                  m0_we;
  logic                  m0_lock;
  logic                  m0_gnt;
  logic                  m0_ack;
  logic [DATA_WIDTH-1:0] m0_do;

  logic                  m1_req;
  logic [ADDR_WIDTH-1:0] m1_a;
  logic [DATA_WIDTH-1:0] m1_di;
  logic                  m1_we;
  logic                  m1_lock;
  logic                  m1_gnt;
  logic                  m1_ack;
  logic [DATA_WIDTH-1:0] m1_do;

  logic [ADDR_WIDTH-1:0] csr_a;
  logic [DATA_WIDTH-1:0] csr_do;
  logic                  csr_we;
  logic [DATA_WIDTH-1:0] csr_di;

  modport slave (
    input  m0_req, m0_a, m0_di, m0_we, m0_lock,
    output m0_gnt, m0_ack, m0_do,
    input  m1_req, m1_a, m1_di, m1_we, m1_lock,
    output m1_gnt, m1_ack, m1_do,
    output csr_a, csr_do, csr_we,
    input  csr_di
  );

  modport master (
    output m0_req, m0_a, m0_di, m0_we, m0_lock,
    input  m0_gnt, m0_ack, m0_do,
    output m1_req, m1_a, m1_di, m1_we, m1_lock,
    input  m1_gnt, m1_ack, m1_do,
    input  csr_a, csr_do, csr_we,
    output csr_di
  );
endinterface

// File: rtl/csr_arbiter.sv
// Two-master CSR bus arbiter: grant -> access strobe -> ack, with
// round-robin or fixed priority and bounded locked bursts.
module csr_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int FIXED_PRIO = 0,
  parameter int HOLD_MAX   = 4
) (
  input logic          clk,
  input logic          rst_n,
  csr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

  localparam logic       FIXED = (FIXED_PRIO != 0);
  localparam logic [3:0] HOLD  = 4'(HOLD_MAX);

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  logic   lockv_q, lockv_d;
  logic   we_q, we_d;
  logic   [3:0] cnt_q, cnt_d;
  logic   [ADDR_WIDTH-1:0] a_q, a_d;
  logic   [DATA_WIDTH-1:0] wd_q, wd_d;
  logic   [DATA_WIDTH-1:0] rd0_q, rd0_d;
  logic   [DATA_WIDTH-1:0] rd1_q, rd1_d;
  logic   hold;
  logic   both;
  logic   win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      lockv_q <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= 4'd0;
      a_q     <= '0;
      wd_q    <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      lockv_q <= lockv_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    lockv_d = lockv_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    wd_d    = wd_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    win     = 1'b0;
    both    = bus.m0_req && bus.m1_req;
    // locked owner keeps the bus until its burst budget is spent
    hold    = lockv_q
           && (last_q ? bus.m1_req : bus.m0_req)
           && (cnt_q < HOLD);
    unique case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          if (hold)
            win = last_q;
          else if (both)
            win = FIXED ? 1'b0 : !last_q;
          else
            win = bus.m1_req;
          cnt_d   = hold ? cnt_q + 4'd1 : 4'd1;
          owner_d = win;
          a_d     = win ? bus.m1_a  : bus.m0_a;
          wd_d    = win ? bus.m1_di : bus.m0_di;
          we_d    = win ? bus.m1_we : bus.m0_we;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (owner_q)
          rd1_d = bus.csr_di;
        else
          rd0_d = bus.csr_di;
        state_d = ACK;
      end
      ACK: begin
        lockv_d = owner_q ? bus.m1_lock : bus.m0_lock;
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // idle drives zeros so the OR-combined read bus also idles at zero
  assign bus.csr_a  = (state_q == IDLE) ? '0 : a_q;
  assign bus.csr_do = (state_q == IDLE) ? '0 : wd_q;
  assign bus.csr_we = (state_q == ACCESS) && we_q;

  assign bus.m0_gnt = (state_q != IDLE) && !owner_q;
  assign bus.m1_gnt = (state_q != IDLE) && owner_q;
  assign bus.m0_ack = (state_q == ACK) && !owner_q;
  assign bus.m1_ack = (state_q == ACK) && owner_q;
  assign bus.m0_do  = rd0_q;
  assign bus.m1_do  = rd1_q;

endmodule

// File: tb/tb_csr_arbiter.sv
// Directed bench for csr_arbiter: vector table on a round-robin instance,
// plus fixed-priority and reset-during-access sequences.
module tb_csr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_init = 1'b1;

  always #5 clk = ~clk;

  csr_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) bus0 ();
  csr_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) bus1 ();

  csr_arbiter #(
    .ADDR_WIDTH(5), .DATA_WIDTH(8),
    .FIXED_PRIO(0), .HOLD_MAX(4)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  csr_arbiter #(
    .ADDR_WIDTH(5), .DATA_WIDTH(8),
    .FIXED_PRIO(1), .HOLD_MAX(4)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  logic [7:0] mem [32];

  assign bus0.csr_di = mem[bus0.csr_a];
  assign bus1.csr_di = {3'b000, bus1.csr_a};

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      mem[3]  <= 8'h3C;
      mem[10] <= 8'h11;
    end else if (bus0.csr_we) begin
      mem[bus0.csr_a] <= bus0.csr_do;
    end
  end

  typedef struct packed {
    logic       req;
    logic       lock;
    logic       we;
    logic [4:0] a;
    logic [7:0] d;
  } mreq_t;

  typedef struct packed {
    mreq_t      m0;
    mreq_t      m1;
    logic       own;
    logic [7:0] rd;
  } vec_t;

  localparam mreq_t NO = '0;

  int errors = 0;
  int checks = 0;
  vec_t vt [21];
  logic [7:0] exp_do [2];
  mreq_t w;
  int n;

  function automatic mreq_t rd(input logic [4:0] ad);
    rd = '{req: 1'b1, lock: 1'b0, we: 1'b0, a: ad, d: 8'h00};
  endfunction

  function automatic mreq_t lk(input logic [4:0] ad);
    lk = '{req: 1'b1, lock: 1'b1, we: 1'b0, a: ad, d: 8'h00};
  endfunction

  function automatic mreq_t wr(input logic [4:0] ad, input logic [7:0] dd);
    wr = '{req: 1'b1, lock: 1'b0, we: 1'b1, a: ad, d: dd};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input mreq_t x, input mreq_t y);
    bus0.m0_req  = x.req;
    bus0.m0_lock = x.lock;
    bus0.m0_we   = x.we;
    bus0.m0_a    = x.a;
    bus0.m0_di   = x.d;
    bus0.m1_req  = y.req;
    bus0.m1_lock = y.lock;
    bus0.m1_we   = y.we;
    bus0.m1_a    = y.a;
    bus0.m1_di   = y.d;
  endtask

  task automatic wait_gnt0();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus0.m0_gnt || bus0.m1_gnt) && n < 6);
  endtask

  task automatic wait_gnt1();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus1.m0_gnt || bus1.m1_gnt) && n < 6);
  endtask

  initial begin
    vt[0]  = '{m0: wr(5'h0A, 8'hA5), m1: NO, own: 1'b0, rd: 8'h11};
    vt[1]  = '{m0: NO, m1: rd(5'h03), own: 1'b1, rd: 8'h3C};
    vt[2]  = '{m0: rd(5'h0A), m1: wr(5'h05, 8'h77), own: 1'b0, rd: 8'hA5};
    vt[3]  = '{m0: rd(5'h05), m1: wr(5'h05, 8'h77), own: 1'b1, rd: 8'h00};
    vt[4]  = '{m0: rd(5'h05), m1: rd(5'h0A), own: 1'b0, rd: 8'h77};
    vt[5]  = '{m0: wr(5'h03, 8'hC3), m1: rd(5'h0A), own: 1'b1, rd: 8'hA5};
    vt[6]  = '{m0: wr(5'h03, 8'hC3), m1: NO, own: 1'b0, rd: 8'h3C};
    vt[7]  = '{m0: NO, m1: lk(5'h03), own: 1'b1, rd: 8'hC3};
    for (int i = 8; i < 11; i++)
      vt[i] = '{m0: rd(5'h0A), m1: lk(5'h05), own: 1'b1, rd: 8'h77};
    vt[11] = '{m0: rd(5'h0A), m1: lk(5'h05), own: 1'b0, rd: 8'hA5};
    for (int i = 12; i < 17; i++)
      vt[i] = '{m0: NO, m1: lk(5'h05), own: 1'b1, rd: 8'h77};
    for (int i = 17; i < 20; i++)
      vt[i] = '{m0: rd(5'h03), m1: lk(5'h05), own: 1'b1, rd: 8'h77};
    vt[20] = '{m0: rd(5'h03), m1: lk(5'h05), own: 1'b0, rd: 8'hC3};

    drive(NO, NO);
    bus1.m0_req = 1'b0; bus1.m0_lock = 1'b0; bus1.m0_we = 1'b0;
    bus1.m0_a = 5'h00; bus1.m0_di = 8'h00;
    bus1.m1_req = 1'b0; bus1.m1_lock = 1'b0; bus1.m1_we = 1'b0;
    bus1.m1_a = 5'h00; bus1.m1_di = 8'h00;
    exp_do[0] = 8'h00;
    exp_do[1] = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_ctl", 32'({bus0.m0_gnt, bus0.m1_gnt, bus0.m0_ack, bus0.m1_ack, bus0.csr_we}), 32'h0);
    check("rst_csr", 32'({bus0.csr_a, bus0.csr_do}), 32'h0);
    check("rst_do", 32'({bus0.m0_do, bus0.m1_do}), 32'h0);
    rst_n = 1'b1;
    mem_init = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 21; i++) begin
      drive(vt[i].m0, vt[i].m1);
      w = vt[i].own ? vt[i].m1 : vt[i].m0;
      wait_gnt0();
      check($sformatf("v%0d_lat", i), 32'(n), 32'd2);
      check($sformatf("v%0d_gnt", i), 32'({bus0.m1_gnt, bus0.m0_gnt}), vt[i].own ? 32'd2 : 32'd1);
      check($sformatf("v%0d_a", i), 32'(bus0.csr_a), 32'(w.a));
      check($sformatf("v%0d_wd", i), 32'(bus0.csr_do), 32'(w.d));
      check($sformatf("v%0d_we", i), 32'(bus0.csr_we), 32'(w.we));
      @(negedge clk);
      exp_do[vt[i].own] = vt[i].rd;
      check($sformatf("v%0d_ack", i), 32'({bus0.m1_ack, bus0.m0_ack}), vt[i].own ? 32'd2 : 32'd1);
      check($sformatf("v%0d_hold", i), 32'({bus0.m1_gnt, bus0.m0_gnt, bus0.csr_we}), vt[i].own ? 32'd4 : 32'd2);
      check($sformatf("v%0d_do0", i), 32'(bus0.m0_do), 32'(exp_do[0]));
      check($sformatf("v%0d_do1", i), 32'(bus0.m1_do), 32'(exp_do[1]));
      @(posedge clk); #1;
    end
    drive(NO, NO);

    // fixed priority: master 1 starves while master 0 keeps requesting
    bus1.m0_req = 1'b1; bus1.m0_a = 5'h01;
    bus1.m1_req = 1'b1; bus1.m1_a = 5'h02;
    for (int k = 0; k < 3; k++) begin
      wait_gnt1();
      check($sformatf("fp%0d_lat", k), 32'(n), 32'd2);
      check($sformatf("fp%0d_gnt", k), 32'({bus1.m1_gnt, bus1.m0_gnt}), 32'd1);
      @(negedge clk);
      check($sformatf("fp%0d_ack", k), 32'({bus1.m1_ack, bus1.m0_ack}), 32'd1);
      check($sformatf("fp%0d_do", k), 32'(bus1.m0_do), 32'h01);
    end
    @(posedge clk); #1;
    bus1.m0_req = 1'b0;
    wait_gnt1();
    check("fp_m1_lat", 32'(n), 32'd2);
    check("fp_m1_gnt", 32'({bus1.m1_gnt, bus1.m0_gnt}), 32'd2);
    @(negedge clk);
    check("fp_m1_ack", 32'({bus1.m1_ack, bus1.m0_ack}), 32'd2);
    check("fp_m1_do", 32'(bus1.m1_do), 32'h02);
    @(posedge clk); #1;
    bus1.m1_req = 1'b0;

    // reset lands in the middle of a master 0 write strobe
    @(posedge clk); #1;
    drive(wr(5'h1F, 8'h99), NO);
    wait_gnt0();
    check("rm_gnt", 32'({bus0.m1_gnt, bus0.m0_gnt, bus0.csr_we}), 32'd3);
    drive(NO, rd(5'h0A));
    #1 rst_n = 1'b0;
    #1;
    check("rm_async", 32'({bus0.m1_gnt, bus0.m0_gnt, bus0.csr_we}), 32'd0);
    check("rm_csr_a", 32'(bus0.csr_a), 32'h0);
    @(negedge clk);
    check("rm_noack", 32'({bus0.m1_ack, bus0.m0_ack}), 32'd0);
    check("rm_do", 32'({bus0.m0_do, bus0.m1_do}), 32'h0);
    rst_n = 1'b1;
    wait_gnt0();
    check("rm_lat", 32'(n), 32'd1);
    check("rm_m1_gnt", 32'({bus0.m1_gnt, bus0.m0_gnt}), 32'd2);
    check("rm_m1_a", 32'(bus0.csr_a), 32'h0A);
    @(negedge clk);
    check("rm_m1_ack", 32'({bus0.m1_ack, bus0.m0_ack}), 32'd2);
    check("rm_m1_do", 32'(bus0.m1_do), 32'hA5);
    check("rm_nowrite", 32'(mem[31]), 32'h00);
    @(posedge clk); #1;
    drive(NO, NO);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_arbiter.md
Name: csr_arbiter

Overview:
- Shares the internal 5-bit-address / 8-bit-data CSR bus between two masters.
  - Master 0: the I2C slave.
  - Master 1: an on-chip sequencer, e.g. a UFM default-config loader.
- Sits between the masters and the OR-combined CSR slave read bus.
- Sequences each access as grant, access (write-enable strobe) and acknowledge, and returns registered read data.
- Supports round-robin or fixed priority, plus bounded locked bursts.

Parameters:
- ADDR_WIDTH, 5: CSR address width.
- DATA_WIDTH, 8: CSR data width.
- FIXED_PRIO, 0: 0 = round-robin between masters; 1 = master 0 always wins simultaneous requests.
- HOLD_MAX, 4: maximum consecutive grants to one master while its lock is asserted (1..15).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 access request; hold until m0_ack.
- m0_a  in  ADDR_WIDTH  master 0 address; stable while req.
- m0_di  in  DATA_WIDTH  master 0 write data.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_lock  in  1  master 0 requests to keep the bus after this access.
- m0_gnt  out  1  master 0 owns the bus (level).
- m0_ack  out  1  one-cycle completion pulse.
- m0_do  out  DATA_WIDTH  read data, valid when m0_ack is high, held afterwards.
- m1_req, m1_a, m1_di, m1_we, m1_lock, m1_gnt, m1_ack, m1_do: same as master 0.
- csr_a  out  ADDR_WIDTH  bus address.
- csr_do  out  DATA_WIDTH  bus write data.
- csr_we  out  1  bus write strobe.
- csr_di  in  DATA_WIDTH  OR-combined slave read data.

Behaviour:
- Reset is asynchronous, active-low:
  - State IDLE.
  - All gnt, ack and csr_we are 0.
  - csr_a, csr_do, m0_do and m1_do are 0.
  - last_owner = 1, so master 0 wins the first tie.
  - burst_cnt = 0 and lock_valid = 0.
- FSM states are IDLE, ACCESS and ACK.
- IDLE:
  - csr_a, csr_do and csr_we are driven 0, so slave read data is 0 when idle.
  - Winner selection, in order:
    - If lock_valid is set, the previous owner is still requesting, and burst_cnt < HOLD_MAX, the previous owner wins.
    - Otherwise, with one request, that master wins.
    - Otherwise, with both requesting: FIXED_PRIO=1 picks master 0; FIXED_PRIO=0 picks the master that is not last_owner.
  - On a win:
    - Register owner; assert that master's gnt.
    - Latch its a/di/we into csr_a/csr_do/csr_we.
    - Go to ACCESS.
    - burst_cnt increments if the same owner is re-granted under lock; otherwise it loads 1.
- ACCESS (exactly 1 cycle):
  - csr_a and csr_do are held; csr_we is high for this cycle only, and only for writes.
  - At the clock edge ending ACCESS, csr_di is captured into the owner's do register. It is captured for writes too, reading back the pre-write value.
  - Go to ACK.
- ACK (1 cycle):
  - Owner's ack = 1, gnt stays 1, csr_we = 0, csr_a held.
  - lock_valid <= owner's lock.
  - last_owner <= owner.
  - Go to IDLE, deasserting gnt.
- Latency and throughput:
  - A request sampled in IDLE at edge N gives csr_we high in cycle N+1 and ack high in cycle N+2.
  - Minimum spacing is one access per 3 cycles per bus.
- A master must change req/a/di/we only in the cycle after its ack; in IDLE the arbiter samples the new value.
- Request withdrawn during ACCESS or ACK: the access completes and ack is still pulsed. The arbiter never aborts a started access.
- Burst cut-off:
  - When burst_cnt reaches HOLD_MAX, the next IDLE arbitration ignores lock.
  - If the other master is requesting, it wins and burst_cnt reloads to 1.
  - If not, the locked master is re-granted with burst_cnt reloaded to 1.
- The non-owner's inputs are ignored during ACCESS and ACK; its pending request is served no later than after the current access, or after HOLD_MAX accesses under lock.
- Never both gnt high; never both ack high; ack only to the current owner.
- Reset asserted mid-ACCESS: csr_we drops immediately (asynchronous), no ack is issued, and the returned state is as at reset. Slave state from a completed strobe is not rolled back.
- Widths: no arithmetic on data paths; burst_cnt is 4 bits and saturates at HOLD_MAX.

Test Plan:
- Single write: m0 writes 0xA5 to address 0x0A → csr_a=0x0A, csr_do=0xA5, csr_we high exactly 1 cycle, 1 cycle after grant; m0_ack 2 cycles after the IDLE sample; m1_gnt stays 0 throughout.
- Read: slave model returns 0x3C at address 0x03; m1 reads 0x03 → m1_do=0x3C on m1_ack; csr_we stays 0; m0_do unchanged.
- Round-robin (FIXED_PRIO=0): both masters request continuously after reset → grant order m0, m1, m0, m1; each ack goes to the matching master; one access every 3 cycles.
- Lock burst (HOLD_MAX=4): m1 holds lock=1 and req=1 while m0 also requests → 4 consecutive m1 accesses, then m0 granted; with m0 idle, m1 continues with burst_cnt reset to 1.
- Fixed priority (FIXED_PRIO=1): both request continuously → only m0 is granted, m1 starves; after m0 drops req, m1 is granted in the next IDLE.
- Reset mid-access: pull rst_n low during an m0 write ACCESS → csr_we=0 and gnt=0 immediately, no m0_ack; after release, a pending m1 request is granted on the first IDLE edge.
